// File: rtl/dmem_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS registers on the data bus, 8N1 serial out.
// Latency: read data one cycle after the address edge; a byte written to an idle TX starts its start bit after the next edge.
// Backpressure: none on the bus; a write to a full FIFO with no same-cycle pop is dropped and sets a sticky overflow flag.
//
// Ports:
//   clk, rst (async, active-low)             clock and reset
//   io_dmem_addr/wdata/wmask                 core data-bus request (wmask==0 means read)
//   io_dmem_rdata                            registered read data
//   uart_tx                                  serial line, idle high, driven from a flop
//   irq_tx_empty                             FIFO empty and shifter idle

// Small synchronous FIFO: head is visible combinationally on o_pop_dat.
// Latency: a pushed entry is visible at the head after the push edge.
// Backpressure: push is accepted when not full, or when full and a pop happens in the same cycle.
module dmem_uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push_vld,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop_rdy,
    output logic [WIDTH-1:0]         o_pop_dat,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_pop_dat = r_mem[r_rd_ptr];
    assign w_pop     = i_pop_rdy && !o_empty;
    assign w_push    = i_push_vld && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end
endmodule

module dmem_uart_tx #(
    parameter int          CLOCK_FREQ = 100_000_000,
    parameter int          BAUD_RATE  = 115_200,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_dmem_addr,
    input  logic [31:0] io_dmem_wdata,
    input  logic [3:0]  io_dmem_wmask,
    output logic [31:0] io_dmem_rdata,
    output logic        uart_tx,
    output logic        irq_tx_empty
);
    localparam int DIV_RAW = CLOCK_FREQ / BAUD_RATE;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = $clog2(DIV + 1);
    localparam int FAW     = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_ovf;
    logic [31:0]   r_rdata;

    logic          w_sel;
    logic [1:0]    w_off;
    logic          w_push_req;
    logic          w_clr_ovf;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_head;
    logic [FAW:0]  w_count;
    logic          w_busy;
    logic          w_bit_end;
    logic [31:0]   w_rdata;
    logic          w_unused;

    assign w_sel      = (io_dmem_addr[31:4] == BASE_ADDR[31:4]);
    assign w_off      = io_dmem_addr[3:2];
    assign w_push_req = w_sel && (w_off == 2'd0) && io_dmem_wmask[0];
    assign w_clr_ovf  = w_sel && (w_off == 2'd1) && io_dmem_wmask[0] && io_dmem_wdata[3];
    assign w_busy     = (r_state != S_IDLE);
    assign w_pop      = !w_busy && !w_empty;
    assign w_bit_end  = (r_cnt == DIV_LAST);
    assign w_unused   = &{1'b0, io_dmem_addr[1:0], io_dmem_wdata[31:8], io_dmem_wmask[3:1]};

    dmem_uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push_vld (w_push_req),
        .i_push_dat (io_dmem_wdata[7:0]),
        .i_pop_rdy  (w_pop),
        .o_pop_dat  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    // Shifter. r_tx is loaded one edge ahead of each phase so the line comes
    // straight from a flop and changes exactly on the phase boundaries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_shift <= w_head;
                        r_cnt   <= '0;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            // Shift right so the next bit is always at [1] before the shift.
                            r_idx   <= r_idx + 1'b1;
                            r_tx    <= r_shift[1];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // Overflow only when the dropped byte had no same-edge pop to make room.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (w_push_req && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end else if (w_clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_sel && (w_off == 2'd1)) begin
            w_rdata = {17'd0, 7'(w_count), 4'd0, r_ovf, w_busy, w_empty, w_full};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rdata;
        end
    end

    assign io_dmem_rdata = r_rdata;
    assign uart_tx       = r_tx;
    assign irq_tx_empty  = w_empty && !w_busy;
endmodule

// File: tb/tb_dmem_uart_tx.sv
`timescale 1ns/1ps
// Bench for dmem_uart_tx: register-access vector table, hand-written frame/overflow/reset
// sequences, and a randomized phase, all checked every cycle against a queue-based model
// of the FIFO and of the serial line waveform.
module tb_dmem_uart_tx;
    localparam int          DIV   = 10;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [31:0] A_TX  = BASE;
    localparam logic [31:0] A_ST  = BASE + 32'h4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wmask = '0;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;

    dmem_uart_tx #(
        .CLOCK_FREQ (100_000_000),
        .BAUD_RATE  (10_000_000),
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .io_dmem_addr  (addr),
        .io_dmem_wdata (wdata),
        .io_dmem_wmask (wmask),
        .io_dmem_rdata (rdata),
        .uart_tx       (tx),
        .irq_tx_empty  (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO contents as a byte queue, the frame in flight as a queue of
    // per-cycle line levels (head = level currently on the wire).
    logic [7:0]  m_fifo[$];
    bit          m_line[$];
    bit          m_ovf;
    logic [31:0] m_rdata;
    logic        m_tx;
    logic        m_irq;

    function automatic logic [31:0] m_status();
        bit full, empty, busy;
        full  = (m_fifo.size() == DEPTH);
        empty = (m_fifo.size() == 0);
        busy  = (m_line.size() > 0);
        return {17'd0, 7'(m_fifo.size()), 4'd0, m_ovf, busy, empty, full};
    endfunction

    task automatic model_outputs();
        m_tx  = (m_line.size() > 0) ? m_line[0] : 1'b1;
        m_irq = (m_fifo.size() == 0) && (m_line.size() == 0);
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_line.delete();
        m_ovf   = 1'b0;
        m_rdata = '0;
        model_outputs();
    endtask

    task automatic model_edge();
        logic [31:0] rd;
        bit          sel, idle_b, popping, full_b;
        logic [1:0]  off;
        logic [7:0]  b;
        rd      = '0;
        sel     = (addr[31:4] == BASE[31:4]);
        off     = addr[3:2];
        if (sel && off == 2'd1) rd = m_status();
        idle_b  = (m_line.size() == 0);
        popping = idle_b && (m_fifo.size() > 0);
        full_b  = (m_fifo.size() == DEPTH);
        if (!idle_b) void'(m_line.pop_front());
        if (popping) begin
            b = m_fifo.pop_front();
            for (int k = 0; k < 10; k++)
                for (int j = 0; j < DIV; j++)
                    m_line.push_back((k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1]);
        end
        if (sel && off == 2'd0 && wmask[0]) begin
            if (!full_b || popping) m_fifo.push_back(wdata[7:0]);
            else                    m_ovf = 1'b1;
        end
        if (sel && off == 2'd1 && wmask[0] && wdata[3]) m_ovf = 1'b0;
        m_rdata = rd;
        model_outputs();
    endtask

    // One clock: drive at the negedge, model at the posedge, compare at the next negedge.
    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr  = a;
        wdata = d;
        wmask = m;
        @(posedge clk);
        if (rst) model_edge();
        else     model_reset();
        @(negedge clk);
        check("line", {31'd0, tx}, {31'd0, m_tx});
        check("irq", {31'd0, irq}, {31'd0, m_irq});
        check("rdata", rdata, m_rdata);
    endtask

    task automatic idle();
        step(32'h0, 32'h0, 4'h0);
    endtask

    task automatic wait_drained(input string name);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < 2000) begin
            idle();
            n++;
        end
        check(name, {31'd0, irq}, 32'd1);
        idle();
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs[11];
    bit          tr[205];
    logic [9:0]  frame;
    int          n;
    int          r;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_irq", {31'd0, irq}, 32'd1);
        check("reset_rdata", rdata, 32'd0);
        rst = 1'b1;

        // Register-access table from the reset state: read value appears after the access edge.
        vecs[0]  = '{A_ST,               32'h0,         4'h0, 32'h2, "rd_status_reset"};
        vecs[1]  = '{A_TX,               32'h0,         4'h0, 32'h0, "rd_txdata"};
        vecs[2]  = '{BASE + 32'h8,       32'h0,         4'h0, 32'h0, "rd_off8"};
        vecs[3]  = '{BASE + 32'hC,       32'hFFFF_FFFF, 4'hF, 32'h0, "wr_offC"};
        vecs[4]  = '{BASE + 32'h20,      32'h41,        4'hF, 32'h0, "wr_base_plus_20"};
        vecs[5]  = '{32'h2000_0000,      32'h42,        4'h1, 32'h0, "wr_far_addr"};
        vecs[6]  = '{A_ST,               32'h0,         4'h0, 32'h2, "rd_status_no_enq"};
        vecs[7]  = '{A_ST,               32'hFFFF_FFF7, 4'hF, 32'h2, "wr_status_ro"};
        vecs[8]  = '{A_ST,               32'h0,         4'h0, 32'h2, "rd_status_ro"};
        vecs[9]  = '{A_TX,               32'hAA,        4'hE, 32'h0, "wr_txdata_mask0_off"};
        vecs[10] = '{A_ST,               32'h0,         4'h0, 32'h2, "rd_status_final"};
        foreach (vecs[i]) begin
            step(vecs[i].a, vecs[i].d, vecs[i].m);
            check(vecs[i].name, rdata, vecs[i].exp);
        end

        // Single 0xA5 frame: start, LSB-first data, stop, each DIV cycles.
        step(A_TX, 32'hA5, 4'h1);
        check("a5_line_high_at_write", {31'd0, tx}, 32'd1);
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            idle();
            n++;
        end
        check("a5_start_latency", n, 1);
        tr[0] = tx;
        for (int i = 1; i <= 100; i++) begin
            idle();
            tr[i] = tx;
        end
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 100; i++) check("a5_frame", {31'd0, tr[i]}, {31'd0, frame[i/DIV]});
        check("a5_idle_after_stop", {31'd0, tr[100]}, 32'd1);
        check("a5_irq_back", {31'd0, irq}, 32'd1);
        idle();

        // Six back-to-back writes: first popped, four queued, sixth dropped.
        for (int i = 0; i < 6; i++) step(A_TX, 32'h10 + i, 4'h1);
        step(A_ST, 32'h0, 4'h0);
        check("ovf_status", rdata, 32'h0000_040D);
        step(A_ST, 32'h8, 4'h1);
        check("clr_pre_status", rdata, 32'h0000_040D);
        step(A_ST, 32'h0, 4'h0);
        check("clr_status", rdata, 32'h0000_0405);
        wait_drained("drain_after_ovf");

        // Back-to-back frames: exactly one idle cycle between stop and next start.
        step(A_TX, 32'h55, 4'h1);
        step(A_TX, 32'h0F, 4'h1);
        tr[0] = tx;
        for (int i = 1; i < 205; i++) begin
            idle();
            tr[i] = tx;
        end
        check("b2b_first_start", {31'd0, tr[0]}, 32'd0);
        check("b2b_stop_end", {31'd0, tr[99]}, 32'd1);
        check("b2b_gap", {31'd0, tr[100]}, 32'd1);
        check("b2b_second_start", {31'd0, tr[101]}, 32'd0);
        check("b2b_second_start_last", {31'd0, tr[110]}, 32'd0);
        check("b2b_second_bit0", {31'd0, tr[111]}, 32'd1);
        wait_drained("drain_after_b2b");

        // Reset in the middle of data bit 3 with a second byte queued.
        step(A_TX, 32'hF0, 4'h1);
        step(A_TX, 32'h33, 4'h1);
        repeat (45) idle();
        check("pre_rst_bit3", {31'd0, tx}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_async_tx", {31'd0, tx}, 32'd1);
        check("rst_async_irq", {31'd0, irq}, 32'd1);
        check("rst_async_rdata", rdata, 32'd0);
        model_reset();
        idle();
        idle();
        rst = 1'b1;
        step(A_ST, 32'h0, 4'h0);
        check("post_rst_status", rdata, 32'h0000_0002);
        repeat (20) idle();

        // Randomized traffic: bursts that overflow, then sparse phases that drain.
        for (int round = 0; round < 4; round++) begin
            for (int c = 0; c < 800; c++) begin
                r = $urandom_range(0, 99);
                if ((c < 300 && r < 20) || (c >= 300 && r < 1))
                    step(A_TX, $urandom, 4'($urandom) | 4'h1);
                else if (r < 35)
                    step(A_ST, 32'h0, 4'h0);
                else if (r < 40)
                    step(A_ST, $urandom, 4'($urandom));
                else if (r < 45)
                    step(BASE + {26'd0, 4'($urandom), 2'd0} + 32'h10 * $urandom_range(0, 2), $urandom, 4'($urandom));
                else if (r < 48)
                    step($urandom, $urandom, 4'($urandom));
                else
                    idle();
            end
        end
        wait_drained("drain_after_random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
